dmem_bridge: RTL

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 42 ++++
 rtl/dmem_bridge.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types for the CPU data-memory bridge: access sizes, FSM states and
// the alignment-fault rule used at request acceptance.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } dmem_state_t;

  // Size 2'b11 is reserved and always faults.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: access_fault = 1'b0;
      SZ_HALF: access_fault = off[0];
      SZ_WORD: access_fault = |off;
      default: access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write
// data, plus load lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  mem_size_t             i_size,
  input  logic [1:0]            i_off,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [3:0]            o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] shifted;

  // Move the addressed lane(s) down to bit 0 before extension.
  assign shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = shifted;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// CPU load/store to single-port synchronous RAM bridge with configurable read
// wait states; one access in flight, response pulse per accepted request.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-3:0] o_ram_addr,
  output logic [3:0]            o_ram_be,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  dmem_state_t           state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  hold_q;
  logic                  we_q, uns_q, err_q;
  mem_size_t             size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;

  logic                  accept, req_ready, fault_in, ram_vis, capture;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_rep, rdata_ext;

  assign fault_in = access_fault(i_req_size, i_req_addr[1:0]);
  assign capture  = (state_q == ST_WAIT) && (cnt_q == WS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        if (i_req_valid) begin
          accept  = 1'b1;
          state_d = fault_in ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d   = '0;
        state_d = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (capture) state_d = ST_RESP;
        else         cnt_d   = cnt_q + 3'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= (state_q == ST_ACCESS);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= i_req_we;
        uns_q   <= i_req_unsigned;
        err_q   <= fault_in;
        size_q  <= mem_size_t'(i_req_size);
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
      end
      if (capture) rdata_q <= rdata_ext;
    end
  end

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_size     (size_q),
    .i_off      (addr_q[1:0]),
    .i_unsigned (uns_q),
    .i_wdata    (wdata_q),
    .i_rdata    (i_ram_rdata),
    .o_be       (be),
    .o_wdata    (wdata_rep),
    .o_rdata    (rdata_ext)
  );

  // RAM-side fields are presented for the strobe cycle and the one after it.
  assign ram_vis     = (state_q == ST_ACCESS) || hold_q;
  assign o_ram_en    = (state_q == ST_ACCESS);
  assign o_ram_we    = ram_vis & we_q;
  assign o_ram_addr  = ram_vis ? addr_q[ADDR_WIDTH-1:2] : '0;
  assign o_ram_be    = ram_vis ? be : 4'b0000;
  assign o_ram_wdata = ram_vis ? wdata_rep : '0;

  assign o_req_ready = req_ready & ~i_rst;
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_err   = o_rsp_valid & err_q;
  assign o_rsp_rdata = (o_rsp_valid && !we_q && !err_q) ? rdata_q : '0;

endmodule
